// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Define MULDIV_DIV_EN to build the divider; otherwise divide OPs finish at once with RESULT=0.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic [4:0]       RD_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [4:0]       WA_OUT,
  output logic             WE_OUT,
  output logic [1:0]       DBG_STATE
);

  // Handshake: START is sampled only in IDLE; DONE is a one-cycle pulse in FIN,
  // and RESULT/WA_OUT stay valid from DONE until the next accepted START.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_r;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg_r;
  logic [WIDTH-1:0]   result_r;
  logic [4:0]         wa_r;

  logic               a_signed, b_signed, a_neg, b_neg, neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               special;
  logic [WIDTH-1:0]   special_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   final_res;

  always_comb begin
    a_signed = (OP == 3'b001) || (OP == 3'b010) || (OP == 3'b100) || (OP == 3'b110);
    b_signed = (OP == 3'b001) || (OP == 3'b100) || (OP == 3'b110);
    a_neg    = a_signed & SRC_A[WIDTH-1];
    b_neg    = b_signed & SRC_B[WIDTH-1];
    a_mag    = a_neg ? -SRC_A : SRC_A;
    b_mag    = b_neg ? -SRC_B : SRC_B;
    // Remainder follows the dividend's sign; products and quotients the XOR.
    neg      = (OP == 3'b110) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
`ifdef MULDIV_DIV_EN
    if (OP[2]) begin
      if (SRC_B == '0) begin
        special     = 1'b1;
        special_res = OP[1] ? SRC_A : '1;
      end else if (!OP[0] && SRC_A == {1'b1, {(WIDTH-1){1'b0}}} && SRC_B == '1) begin
        special     = 1'b1;
        special_res = OP[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
      end
    end
`else
    if (OP[2]) special = 1'b1;
`endif
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] div_shift, div_diff;
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand[WIDTH-1:0]};
  end
`endif

  always_comb begin
    prod      = neg_r ? -acc : acc;
    final_res = (op_r == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    if (op_r[2]) begin
      if (op_r[1]) final_res = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      else         final_res = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = special ? FIN : CALC;
      CALC:    if (cnt == 6'd32) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state != IDLE);
    DONE      = (state == FIN);
    WE_OUT    = DONE && (wa_r != 5'd0);
    DBG_STATE = state;
    RESULT    = result_r;
    WA_OUT    = wa_r;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_r     <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg_r    <= 1'b0;
      result_r <= '0;
      wa_r     <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          op_r  <= OP;
          wa_r  <= RD_IN;
          neg_r <= neg;
          cnt   <= '0;
          if (special) begin
            result_r <= special_res;
          end else if (OP[2]) begin
            acc   <= {{WIDTH{1'b0}}, a_mag};
            mcand <= {{WIDTH{1'b0}}, b_mag};
          end else begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
          end
        end
        CALC: if (cnt != 6'd32) begin
          cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
          if (op_r[2]) begin
            // Restoring step: keep the shifted partial remainder when the subtract borrows.
            if (!div_diff[WIDTH])
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else
`endif
          begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end else begin
          result_r <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a reference model,
// and hand-written sequences for START-ignore, back-to-back START and mid-operation reset.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] SRC_A, SRC_B;
  logic [4:0]  RD_IN;
  logic        BUSY, DONE, WE_OUT;
  logic [31:0] RESULT;
  logic [4:0]  WA_OUT;
  logic [1:0]  DBG_STATE;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .SRC_A(SRC_A), .SRC_B(SRC_B),
    .RD_IN(RD_IN), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .WA_OUT(WA_OUT),
    .WE_OUT(WE_OUT), .DBG_STATE(DBG_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
          3'b100:  return $signed(a) / $signed(b);
          3'b101:  return a / b;
          3'b110:  return $signed(a) % $signed(b);
          default: return a % b;
        endcase
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return 33;
`else
    return op[2] ? 0 : 33;
`endif
  endfunction

  // lat = number of rising edges after the accepting edge before DONE is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input int glitch, input string tag);
    int lat;
    logic [31:0] e;
    @(negedge CLK);
    START = 1'b1; OP = op; SRC_A = a; SRC_B = b; RD_IN = rd;
    @(posedge CLK);
    exp_q.push_back(exp_res);
    #1;
    START = 1'b0;
    OP    = 3'($urandom_range(0, 7));
    SRC_A = $urandom;
    SRC_B = $urandom;
    RD_IN = 5'($urandom_range(0, 31));
    chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
    lat = 0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (glitch != 0) START = (lat == glitch);
    end
    START = 1'b0;
    e = exp_q.pop_front();
    if (!DONE) begin
      chk({tag, "_done_timeout"}, 32'(lat), 32'(exp_lat));
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, RESULT, e);
      chk({tag, "_wa"}, {27'b0, WA_OUT}, {27'b0, rd});
      chk({tag, "_we"}, {31'b0, WE_OUT}, {31'b0, (rd != 5'd0)});
    end
    @(posedge CLK); #1;
    chk({tag, "_done_pulse"}, {31'b0, DONE}, 32'd0);
    chk({tag, "_hold"}, RESULT, e);
  endtask

  initial begin
    int seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] e;
    logic [31:0] res_v;
    int          lat_v;

    vecs[0]  = '{3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         33};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{3'b000, 32'h8000_0000,  32'd2,          5'd31, 32'h0000_0000,  33};
    vecs[5]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd4,  32'h4000_0000,  33};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  33};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  33};
    vecs[8]  = '{3'b101, 32'd9,          32'd0,          5'd8,  32'hFFFF_FFFF,  0};
    vecs[9]  = '{3'b111, 32'd9,          32'd0,          5'd9,  32'd9,          0};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  0};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          0};
    vecs[12] = '{3'b101, 32'd100,        32'd7,          5'd12, 32'd14,         33};
    vecs[13] = '{3'b111, 32'd100,        32'd7,          5'd13, 32'd2,          33};
    vecs[14] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFFD,  33};

    RST_N = 1'b0; START = 1'b0; OP = '0; SRC_A = '0; SRC_B = '0; RD_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy",   {31'b0, BUSY},   32'd0);
    chk("reset_done",   {31'b0, DONE},   32'd0);
    chk("reset_we",     {31'b0, WE_OUT}, 32'd0);
    chk("reset_result", RESULT,          32'd0);
    chk("reset_wa",     {27'b0, WA_OUT}, 32'd0);
    chk("reset_state",  {30'b0, DBG_STATE}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      res_v = vecs[i].res;
      lat_v = vecs[i].lat;
`ifndef MULDIV_DIV_EN
      if (vecs[i].op[2]) begin res_v = 32'd0; lat_v = 0; end
`endif
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res_v, lat_v, 0,
             $sformatf("vec%0d", i));
    end

    // MUL to x0 with a second START pulsed mid-CALC.
    run_op(3'b000, 32'd123, 32'd45, 5'd0, 32'd5535, 33, 10, "x0_glitch");

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), model_res(rop, ra, rb),
             model_lat(rop, ra, rb), 0, $sformatf("rnd%0d", i));
    end

    // START held through the DONE cycle: ignored in FIN, accepted in the following IDLE.
    @(negedge CLK);
    START = 1'b1; OP = 3'b101; SRC_A = 32'd9; SRC_B = 32'd0; RD_IN = 5'd3;
    @(posedge CLK); #1;
`ifdef MULDIV_DIV_EN
    e = 32'hFFFF_FFFF;
`else
    e = 32'd0;
`endif
    chk("b2b_first_done", {31'b0, DONE}, 32'd1);
    chk("b2b_first_result", RESULT, e);
    OP = 3'b000; SRC_A = 32'd3; SRC_B = 32'd5; RD_IN = 5'd4;
    @(posedge CLK); #1;
    chk("b2b_fin_ignored_busy", {31'b0, BUSY}, 32'd0);
    chk("b2b_fin_ignored_result", RESULT, e);
    @(posedge CLK);
    exp_q.push_back(32'd15);
    #1;
    START = 1'b0;
    chk("b2b_second_busy", {31'b0, BUSY}, 32'd1);
    seen = 0;
    while (!DONE && seen < 40) begin
      @(posedge CLK); #1;
      seen++;
    end
    e = exp_q.pop_front();
    chk("b2b_second_latency", 32'(seen), 32'd33);
    chk("b2b_second_result", RESULT, e);
    chk("b2b_second_wa", {27'b0, WA_OUT}, 32'd4);
    @(posedge CLK); #1;

    // Reset asserted at cycle 15 of CALC, released two cycles later.
    @(negedge CLK);
    START = 1'b1; OP = 3'b000; SRC_A = 32'd7; SRC_B = 32'd6; RD_IN = 5'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_busy",   {31'b0, BUSY}, 32'd0);
    chk("rst_mid_result", RESULT, 32'd0);
    chk("rst_mid_wa",     {27'b0, WA_OUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE || WE_OUT || BUSY) seen = 1;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    chk("rst_after_result", RESULT, 32'd0);
    chk("rst_after_state", {30'b0, DBG_STATE}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is supported.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port START, input, 1, a request to start an operation; sampled only in IDLE.
REQ-005 SHALL have port OP, input, 3, the RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port SRC_A, input, 32, operand rs1, taken from register-file RD1.
REQ-007 SHALL have port SRC_B, input, 32, operand rs2, taken from register-file RD2.
REQ-008 SHALL have port RD_IN, input, 5, the destination register index.
REQ-009 SHALL have port BUSY, output, 1, high while an accepted operation is in progress.
REQ-010 SHALL have port DONE, output, 1, a one-cycle pulse marking RESULT valid.
REQ-011 SHALL have port RESULT, output, 32, the operation result; drives register-file WD3.
REQ-012 SHALL have port WA_OUT, output, 5, the captured RD_IN; drives register-file WA3.
REQ-013 SHALL have port WE_OUT, output, 1, equal to DONE AND (WA_OUT != 0); drives register-file WE3.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and FIN.
- IDLE -> CALC on START.
- CALC -> FIN after the iteration count reaches 32.
- FIN -> IDLE unconditionally.
REQ-015 SHALL, on START in IDLE, register OP, SRC_A, SRC_B and RD_IN; later input changes SHALL NOT affect the result.
REQ-016 SHALL ignore START while BUSY; BUSY SHALL be high in CALC and FIN.
REQ-017 SHALL, for START sampled at edge N, raise DONE during the cycle after edge N+33 (fixed 33-cycle latency) for every non-special operation.
REQ-018 SHALL multiply by iterative shift-add, one bit per cycle, over a 64-bit product.
- Operands are sign-adjusted per OP: MULH signed x signed; MULHSU signed x unsigned; MULHU and MUL unsigned.
- MUL returns product[31:0]; the MULH variants return product[63:32].
REQ-019 SHALL divide by restoring division, one quotient bit per cycle, on magnitudes.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
- Applies to signed ops only.
REQ-020 SHALL handle divide by zero (SRC_B=0) as follows:
- DIV and DIVU return 0xFFFFFFFF.
- REM and REMU return SRC_A.
- Go IDLE -> FIN directly, with DONE one cycle after acceptance.
REQ-021 SHALL handle signed overflow (DIV or REM with A=0x80000000, B=0xFFFFFFFF) as follows:
- DIV returns 0x80000000; REM returns 0.
- Same one-cycle path as REQ-020.
REQ-022 SHALL hold RESULT and WA_OUT stable after DONE until the next accepted START.
REQ-023 SHALL allow START in the cycle DONE is high to be ignored (FSM in FIN), and accepted the following cycle in IDLE.

Reset
REQ-024 SHALL, on RST_N low, immediately set:
- State to IDLE.
- BUSY, DONE and WE_OUT to 0.
- RESULT to 0x00000000.
- WA_OUT to 0.
- All internal counters and accumulators to 0.
REQ-025 SHALL, on reset asserted mid-CALC, abort the operation with no DONE or WE_OUT pulse after release.

Configuration
REQ-026 SHALL compile the divider (OP 100-111) only when macro MULDIV_DIV_EN is defined.
REQ-027 SHALL, with MULDIV_DIV_EN undefined, accept divide OPs and complete them on the one-cycle path of REQ-020, with RESULT=0 and DONE and WE_OUT asserted as normal.

Verification
REQ-028 SHALL cover: MUL A=7, B=6, RD_IN=5 -> DONE 33 cycles after START, RESULT=42, WA_OUT=5, WE_OUT=1.
REQ-029 SHALL cover: MULH A=0xFFFFFFFF (-1), B=0xFFFFFFFF; and MULHU with the same operands -> MULH RESULT=0x00000000, MULHU RESULT=0xFFFFFFFE.
REQ-030 SHALL cover: DIV A=-7, B=2; and REM with the same operands -> DIV RESULT=0xFFFFFFFD (-3), REM RESULT=0xFFFFFFFF (-1).
REQ-031 SHALL cover: DIVU A=9, B=0 -> RESULT=0xFFFFFFFF with DONE one cycle after START; REMU with the same operands -> RESULT=9.
REQ-032 SHALL cover: MUL with RD_IN=0 -> DONE=1, WE_OUT=0; a second START pulsed at cycle 10 of CALC -> ignored, first RESULT unchanged.
REQ-033 SHALL cover: RST_N low at cycle 15 of CALC, released 2 cycles later -> BUSY=0, RESULT=0, no DONE within 40 cycles.
